// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants, rx FSM state type and byte-select helpers
//
// Purpose : Ethernet/IPv4/UDP framing constants and the receive FSM state
//           encoding used by my_ip_receive.
// Ports   : none (package)

package eth_pkg;

    typedef enum logic [3:0] {
        RX_IDLE,
        RX_PREAMBLE,
        RX_ETH_HEAD,
        RX_IP_HEAD,
        RX_UDP_HEAD,
        RX_DATA,
        RX_TAIL,
        RX_END,
        RX_DROP
    } rx_state_t;

    localparam logic [3:0]  PREAMBLE_NIB   = 4'h5;
    localparam logic [3:0]  SFD_NIB        = 4'hD;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [15:0] ETH_HDR_LEN    = 16'd14;
    localparam logic [15:0] IP_HDR_LEN     = 16'd20;
    localparam logic [15:0] UDP_HDR_LEN    = 16'd8;
    localparam logic [15:0] MIN_PAYLOAD    = 16'd46;

    // Byte idx of a MAC address in wire order (idx 0 = most significant byte).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        case (idx)
            3'd0:    mac_byte = mac[47:40];
            3'd1:    mac_byte = mac[39:32];
            3'd2:    mac_byte = mac[31:24];
            3'd3:    mac_byte = mac[23:16];
            3'd4:    mac_byte = mac[15:8];
            default: mac_byte = mac[7:0];
        endcase
    endfunction

    // Byte idx of an IPv4 address in wire order (idx 0 = first octet).
    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
        case (idx)
            2'd0:    ip_byte = ip[31:24];
            2'd1:    ip_byte = ip[23:16];
            2'd2:    ip_byte = ip[15:8];
            default: ip_byte = ip[7:0];
        endcase
    endfunction

endpackage

// File: rtl/crc32_d4.sv
// rtl/crc32_d4.sv - Ethernet CRC-32 register, 4-bit data per clock
//
// Purpose : Running CRC-32 (poly 04C11DB7, init all ones, non-reflected
//           register, each nibble fed bit 0 first). After a frame including a
//           good FCS the register holds 32'hC704DD7B.
// Ports   : eth_tx_clk  in   clock
//           sys_rst_n   in   asynchronous active-low reset
//           crc_din     in 4 data nibble
//           crc_en      in   advance the CRC by crc_din
//           crc_clr     in   reload all ones (priority over crc_en)
//           crc_data    out 32 current CRC register

module crc32_d4 (
    input  logic        eth_tx_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  crc_din,
    input  logic        crc_en,
    input  logic        crc_clr,
    output logic [31:0] crc_data
);

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [3:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 4; i++) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
        end
        crc_step = c;
    endfunction

    always_ff @(posedge eth_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            crc_data <= 32'hFFFF_FFFF;
        end else if (crc_clr) begin
            crc_data <= 32'hFFFF_FFFF;
        end else if (crc_en) begin
            crc_data <= crc_step(crc_data, crc_din);
        end
    end

endmodule

// File: rtl/my_ip_receive.sv
// rtl/my_ip_receive.sv - MII UDP/IPv4 frame receiver with MAC/IP filtering
//
// Purpose : Strips preamble/SFD, Ethernet, IPv4 and UDP headers from a nibble
//           stream, filters on destination MAC/IP, emits the UDP payload as
//           big-endian 32-bit words and reports length and FCS status.
//           Drives an external crc32_d4 instance.
// Ports   : eth_tx_clk    in     25 MHz nibble clock
//           sys_rst_n     in     asynchronous active-low reset
//           eth_rxdv      in     nibble valid from PHY
//           eth_rx_data   in  4  nibble from PHY (low nibble of a byte first)
//           crc_data      in 32  running CRC from crc32_d4
//           crc_din       out 4  registered nibble to crc32_d4
//           crc_en        out    crc32_d4 enable, aligned with crc_din
//           crc_clr       out    crc32_d4 clear pulse
//           rec_en        out    payload word strobe
//           rec_data      out 32 payload word, first byte in [31:24]
//           rec_data_num  out 16 UDP payload byte count
//           rec_end       out    frame finished strobe
//           rec_ok        out    with rec_end: FCS good and payload complete

module my_ip_receive
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC   = 48'h12_34_56_78_9A_BC,
    parameter logic [31:0] BOARD_IP    = {8'd169, 8'd254, 8'd1, 8'd23},
    parameter logic [31:0] CRC_RESIDUE = 32'hC704_DD7B
) (
    input  logic        eth_tx_clk,
    input  logic        sys_rst_n,
    input  logic        eth_rxdv,
    input  logic [3:0]  eth_rx_data,
    input  logic [31:0] crc_data,
    output logic [3:0]  crc_din,
    output logic        crc_en,
    output logic        crc_clr,
    output logic        rec_en,
    output logic [31:0] rec_data,
    output logic [15:0] rec_data_num,
    output logic        rec_end,
    output logic        rec_ok
);

    logic        eth_rxdv_d;
    logic [3:0]  eth_rx_data_d;

    rx_state_t   state;
    rx_state_t   state_nxt;

    logic        nib_phase;
    logic [3:0]  nib_lo;
    logic [15:0] byte_cnt;
    logic [15:0] udp_len;
    logic [15:0] payload_len;
    logic [15:0] payload_cnt;
    logic [23:0] word_sr;
    logic        da_mac_ok;
    logic        da_bc_ok;
    logic        pay_done;

    logic        in_frame;
    logic        byte_stb;
    logic [7:0]  cur_byte;
    logic        mac_hit;
    logic        bc_hit;
    logic        da_pass;
    logic        ip_hit;
    logic        last_pay;
    logic [31:0] pay_word;

    always_ff @(posedge eth_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            eth_rxdv_d    <= 1'b0;
            eth_rx_data_d <= 4'h0;
        end else begin
            eth_rxdv_d    <= eth_rxdv;
            eth_rx_data_d <= eth_rx_data;
        end
    end

    // States whose nibbles are covered by the FCS and assembled into bytes.
    assign in_frame = (state == RX_ETH_HEAD) || (state == RX_IP_HEAD) ||
                      (state == RX_UDP_HEAD) || (state == RX_DATA) ||
                      (state == RX_TAIL);
    assign byte_stb = in_frame && eth_rxdv_d && nib_phase;
    assign cur_byte = {eth_rx_data_d, nib_lo};

    assign mac_hit  = (cur_byte == mac_byte(BOARD_MAC, byte_cnt[2:0]));
    assign bc_hit   = (cur_byte == 8'hFF);
    // A DA passes only if every byte matched the same candidate address.
    assign da_pass  = (da_mac_ok && mac_hit) || (da_bc_ok && bc_hit);
    assign ip_hit   = (cur_byte == ip_byte(BOARD_IP, byte_cnt[1:0]));
    assign last_pay = ((payload_cnt + 16'd1) == payload_len);

    // Left-justify the bytes collected so far; unfilled low bytes read 0.
    always_comb begin
        pay_word = 32'h0;
        case (payload_cnt[1:0])
            2'd0:    pay_word = {cur_byte, 24'h0};
            2'd1:    pay_word = {word_sr[7:0], cur_byte, 16'h0};
            2'd2:    pay_word = {word_sr[15:0], cur_byte, 8'h0};
            default: pay_word = {word_sr, cur_byte};
        endcase
    end

    always_ff @(posedge eth_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE: begin
                // The nibble that starts a frame is the first preamble
                // nibble, so PREAMBLE always has at least one 5 behind it.
                if (eth_rxdv_d) begin
                    state_nxt = (eth_rx_data_d == PREAMBLE_NIB) ? RX_PREAMBLE : RX_DROP;
                end
            end
            RX_PREAMBLE: begin
                if (!eth_rxdv_d) begin
                    state_nxt = RX_IDLE;
                end else if (eth_rx_data_d == SFD_NIB) begin
                    state_nxt = RX_ETH_HEAD;
                end else if (eth_rx_data_d != PREAMBLE_NIB) begin
                    state_nxt = RX_DROP;
                end
            end
            RX_ETH_HEAD: begin
                if (!eth_rxdv_d) begin
                    state_nxt = RX_IDLE;
                end else if (byte_stb) begin
                    if (byte_cnt == 16'd5 && !da_pass) begin
                        state_nxt = RX_DROP;
                    end else if (byte_cnt == 16'd12 && cur_byte != ETHERTYPE_IPV4[15:8]) begin
                        state_nxt = RX_DROP;
                    end else if (byte_cnt == ETH_HDR_LEN - 16'd1) begin
                        state_nxt = (cur_byte == ETHERTYPE_IPV4[7:0]) ? RX_IP_HEAD : RX_DROP;
                    end
                end
            end
            RX_IP_HEAD: begin
                if (!eth_rxdv_d) begin
                    state_nxt = RX_IDLE;
                end else if (byte_stb) begin
                    if (byte_cnt == 16'd0 && cur_byte != IP_VER_IHL) begin
                        state_nxt = RX_DROP;
                    end else if (byte_cnt == 16'd9 && cur_byte != IP_PROTO_UDP) begin
                        state_nxt = RX_DROP;
                    end else if (byte_cnt >= 16'd16 && !ip_hit) begin
                        state_nxt = RX_DROP;
                    end else if (byte_cnt == IP_HDR_LEN - 16'd1) begin
                        state_nxt = RX_UDP_HEAD;
                    end
                end
            end
            RX_UDP_HEAD: begin
                if (!eth_rxdv_d) begin
                    state_nxt = RX_IDLE;
                end else if (byte_stb && byte_cnt == UDP_HDR_LEN - 16'd1) begin
                    if (udp_len < UDP_HDR_LEN) begin
                        state_nxt = RX_DROP;
                    end else if (udp_len == UDP_HDR_LEN) begin
                        state_nxt = RX_TAIL;
                    end else begin
                        state_nxt = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (!eth_rxdv_d) begin
                    state_nxt = RX_END;
                end else if (byte_stb && last_pay) begin
                    state_nxt = RX_TAIL;
                end
            end
            RX_TAIL: begin
                if (!eth_rxdv_d) begin
                    state_nxt = RX_END;
                end
            end
            RX_END: begin
                state_nxt = RX_IDLE;
            end
            RX_DROP: begin
                if (!eth_rxdv_d) begin
                    state_nxt = RX_IDLE;
                end
            end
            default: begin
                state_nxt = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge eth_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            nib_phase    <= 1'b0;
            nib_lo       <= 4'h0;
            byte_cnt     <= 16'h0;
            udp_len      <= 16'h0;
            payload_len  <= 16'h0;
            payload_cnt  <= 16'h0;
            word_sr      <= 24'h0;
            da_mac_ok    <= 1'b0;
            da_bc_ok     <= 1'b0;
            pay_done     <= 1'b0;
            crc_din      <= 4'h0;
            crc_en       <= 1'b0;
            crc_clr      <= 1'b0;
            rec_en       <= 1'b0;
            rec_data     <= 32'h0;
            rec_data_num <= 16'h0;
            rec_end      <= 1'b0;
            rec_ok       <= 1'b0;
        end else begin
            crc_clr <= 1'b0;
            rec_en  <= 1'b0;
            rec_end <= 1'b0;
            rec_ok  <= 1'b0;

            // The CRC sees every nibble from the first DA nibble until rxdv
            // falls, including any dangling odd nibble.
            crc_din <= eth_rx_data_d;
            crc_en  <= in_frame && eth_rxdv_d;

            if (in_frame && eth_rxdv_d) begin
                nib_phase <= ~nib_phase;
                if (!nib_phase) begin
                    nib_lo <= eth_rx_data_d;
                end
            end else begin
                nib_phase <= 1'b0;
            end

            if (state_nxt != state) begin
                byte_cnt <= 16'h0;
            end else if (byte_stb && byte_cnt != 16'hFFFF) begin
                byte_cnt <= byte_cnt + 16'd1;
            end

            if (state == RX_PREAMBLE && state_nxt == RX_ETH_HEAD) begin
                crc_clr     <= 1'b1;
                da_mac_ok   <= 1'b1;
                da_bc_ok    <= 1'b1;
                payload_cnt <= 16'h0;
                word_sr     <= 24'h0;
                pay_done    <= 1'b0;
            end

            if (state == RX_ETH_HEAD && byte_stb && byte_cnt < 16'd6) begin
                da_mac_ok <= da_mac_ok && mac_hit;
                da_bc_ok  <= da_bc_ok && bc_hit;
            end

            if (state == RX_UDP_HEAD && byte_stb) begin
                if (byte_cnt == 16'd4) begin
                    udp_len[15:8] <= cur_byte;
                end
                if (byte_cnt == 16'd5) begin
                    udp_len[7:0] <= cur_byte;
                end
                if (byte_cnt == UDP_HDR_LEN - 16'd1 && udp_len >= UDP_HDR_LEN) begin
                    payload_len  <= udp_len - UDP_HDR_LEN;
                    rec_data_num <= udp_len - UDP_HDR_LEN;
                    pay_done     <= (udp_len == UDP_HDR_LEN);
                end
            end

            if (state == RX_DATA && byte_stb) begin
                word_sr <= {word_sr[15:0], cur_byte};
                if (payload_cnt != 16'hFFFF) begin
                    payload_cnt <= payload_cnt + 16'd1;
                end
                if (payload_cnt[1:0] == 2'd3 || last_pay) begin
                    rec_en   <= 1'b1;
                    rec_data <= pay_word;
                end
                if (last_pay) begin
                    pay_done <= 1'b1;
                end
            end

            // END is entered one cycle after rxdv_d falls, by which time the
            // last FCS nibble has been folded into crc_data.
            if (state == RX_END) begin
                rec_end <= 1'b1;
                rec_ok  <= (crc_data == CRC_RESIDUE) && pay_done;
            end
        end
    end

endmodule

// File: tb/tb_my_ip_receive.sv
// tb/tb_my_ip_receive.sv - scoreboard bench for my_ip_receive with crc32_d4

module tb_my_ip_receive;

    logic        eth_tx_clk = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        eth_rxdv   = 1'b0;
    logic [3:0]  eth_rx_data = 4'h0;
    logic [31:0] crc_data;
    logic [3:0]  crc_din;
    logic        crc_en;
    logic        crc_clr;
    logic        rec_en;
    logic [31:0] rec_data;
    logic [15:0] rec_data_num;
    logic        rec_end;
    logic        rec_ok;

    always #20 eth_tx_clk = ~eth_tx_clk;

    my_ip_receive dut (
        .eth_tx_clk   (eth_tx_clk),
        .sys_rst_n    (sys_rst_n),
        .eth_rxdv     (eth_rxdv),
        .eth_rx_data  (eth_rx_data),
        .crc_data     (crc_data),
        .crc_din      (crc_din),
        .crc_en       (crc_en),
        .crc_clr      (crc_clr),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_data_num (rec_data_num),
        .rec_end      (rec_end),
        .rec_ok       (rec_ok)
    );

    crc32_d4 u_crc (
        .eth_tx_clk (eth_tx_clk),
        .sys_rst_n  (sys_rst_n),
        .crc_din    (crc_din),
        .crc_en     (crc_en),
        .crc_clr    (crc_clr),
        .crc_data   (crc_data)
    );

    typedef struct {
        logic [15:0] num;
        logic        ok;
    } end_t;

    logic [31:0] exp_words[$];
    end_t        exp_ends[$];
    logic [7:0]  pay[$];
    logic [7:0]  frm[$];
    int          checks   = 0;
    int          failures = 0;

    localparam logic [47:0] MAC_BOARD = 48'h12_34_56_78_9A_BC;
    localparam logic [47:0] MAC_OTHER = 48'h11_22_33_44_55_66;
    localparam logic [47:0] MAC_BCAST = 48'hFF_FF_FF_FF_FF_FF;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Monitor: every DUT output strobe is matched against the scoreboard.
    always @(negedge eth_tx_clk) begin
        if (sys_rst_n) begin
            if (rec_en) begin
                if (exp_words.size() == 0) begin
                    chk("unexpected_rec_en", rec_data, 32'hxxxx_xxxx);
                end else begin
                    chk("rec_data", rec_data, exp_words.pop_front());
                end
            end
            if (rec_end) begin
                if (exp_ends.size() == 0) begin
                    chk("unexpected_rec_end", {15'h0, rec_ok, rec_data_num}, 32'hxxxx_xxxx);
                end else begin
                    end_t e;
                    e = exp_ends.pop_front();
                    chk("rec_data_num", {16'h0, rec_data_num}, {16'h0, e.num});
                    chk("rec_ok", {31'h0, rec_ok}, {31'h0, e.ok});
                end
            end
        end
    end

    task automatic push_end(input logic [15:0] num, input logic ok);
        end_t e;
        e.num = num;
        e.ok  = ok;
        exp_ends.push_back(e);
    endtask

    // DA..pad followed by FCS (reflected CRC-32, sent low byte first).
    task automatic build_frame(input logic [47:0] da, input logic [7:0] ip_last);
        int          ulen;
        int          tot;
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(da[47 - 8 * i -: 8]);
        frm.push_back(8'h02); frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h01);
        frm.push_back(8'h08); frm.push_back(8'h00);
        ulen = 8 + pay.size();
        tot  = 20 + ulen;
        frm.push_back(8'h45); frm.push_back(8'h00);
        frm.push_back(8'(tot >> 8)); frm.push_back(8'(tot));
        frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h40); frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(8'h11); frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'd169); frm.push_back(8'd254); frm.push_back(8'd1); frm.push_back(8'd1);
        frm.push_back(8'd169); frm.push_back(8'd254); frm.push_back(8'd1); frm.push_back(ip_last);
        frm.push_back(8'h04); frm.push_back(8'hD2); frm.push_back(8'h04); frm.push_back(8'hD2);
        frm.push_back(8'(ulen >> 8)); frm.push_back(8'(ulen));
        frm.push_back(8'h00); frm.push_back(8'h00);
        foreach (pay[i]) frm.push_back(pay[i]);
        while (frm.size() < 60) frm.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        frm.push_back(c[7:0]); frm.push_back(c[15:8]);
        frm.push_back(c[23:16]); frm.push_back(c[31:24]);
    endtask

    // cut < 0 sends the whole frame; hold_dv leaves rxdv high on return.
    task automatic send_frame(input int cut, input bit flip_last, input bit hold_dv);
        logic [3:0] nibs[$];
        int         n;
        for (int i = 0; i < 15; i++) nibs.push_back(4'h5);
        nibs.push_back(4'hD);
        foreach (frm[i]) begin
            nibs.push_back(frm[i][3:0]);
            nibs.push_back(frm[i][7:4]);
        end
        if (flip_last) nibs[nibs.size() - 1] = ~nibs[nibs.size() - 1];
        n = (cut >= 0 && cut < nibs.size()) ? cut : nibs.size();
        for (int i = 0; i < n; i++) begin
            @(posedge eth_tx_clk); #1;
            eth_rxdv    = 1'b1;
            eth_rx_data = nibs[i];
        end
        if (!hold_dv) begin
            @(posedge eth_tx_clk); #1;
            eth_rxdv    = 1'b0;
            eth_rx_data = 4'h0;
            repeat (12) @(posedge eth_tx_clk);
        end
    endtask

    task automatic load_http;
        pay = {8'h68, 8'h74, 8'h74, 8'h70, 8'h3a, 8'h2f, 8'h2f, 8'h77, 8'h77, 8'h77};
    endtask

    task automatic good_http_frame;
        load_http();
        build_frame(MAC_BOARD, 8'd23);
        exp_words.push_back(32'h6874_7470);
        exp_words.push_back(32'h3a2f_2f77);
        exp_words.push_back(32'h7777_0000);
        push_end(16'd10, 1'b1);
        send_frame(-1, 1'b0, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rec_en"},  {31'h0, rec_en},  32'h0);
        chk({tag, "_rec_end"}, {31'h0, rec_end}, 32'h0);
        chk({tag, "_rec_ok"},  {31'h0, rec_ok},  32'h0);
        chk({tag, "_rec_data"}, rec_data, 32'h0);
        chk({tag, "_rec_data_num"}, {16'h0, rec_data_num}, 32'h0);
        chk({tag, "_crc_ctl"}, {26'h0, crc_din, crc_en, crc_clr}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge eth_tx_clk);
        chk_outputs_zero("reset");
        @(posedge eth_tx_clk); #1;
        sys_rst_n = 1'b1;
        repeat (4) @(posedge eth_tx_clk);

        // 1: good 10-byte payload
        good_http_frame();

        // 2: corrupted FCS nibble
        load_http();
        build_frame(MAC_BOARD, 8'd23);
        exp_words.push_back(32'h6874_7470);
        exp_words.push_back(32'h3a2f_2f77);
        exp_words.push_back(32'h7777_0000);
        push_end(16'd10, 1'b0);
        send_frame(-1, 1'b1, 1'b0);

        // 3: filtered DA, filtered IP, then a normal frame
        load_http();
        build_frame(MAC_OTHER, 8'd23);
        send_frame(-1, 1'b0, 1'b0);
        build_frame(MAC_BOARD, 8'd24);
        send_frame(-1, 1'b0, 1'b0);
        good_http_frame();

        // 4: broadcast DA, 4-byte payload
        pay = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build_frame(MAC_BCAST, 8'd23);
        exp_words.push_back(32'hDEAD_BEEF);
        push_end(16'd4, 1'b1);
        send_frame(-1, 1'b0, 1'b0);

        // 5: rxdv drops after 6 of 10 payload bytes
        load_http();
        build_frame(MAC_BOARD, 8'd23);
        exp_words.push_back(32'h6874_7470);
        push_end(16'd10, 1'b0);
        send_frame(16 + (42 + 6) * 2, 1'b0, 1'b0);

        // 6: reset mid-DATA, then a normal frame
        load_http();
        build_frame(MAC_BOARD, 8'd23);
        exp_words.push_back(32'h6874_7470);
        send_frame(16 + (42 + 5) * 2, 1'b0, 1'b1);
        repeat (3) @(posedge eth_tx_clk);
        #1;
        sys_rst_n = 1'b0;
        @(negedge eth_tx_clk);
        chk_outputs_zero("midreset");
        @(posedge eth_tx_clk); #1;
        eth_rxdv    = 1'b0;
        eth_rx_data = 4'h0;
        repeat (3) @(posedge eth_tx_clk);
        #1;
        sys_rst_n = 1'b1;
        repeat (4) @(posedge eth_tx_clk);
        good_http_frame();

        // 7: UDP length 8, empty payload
        pay.delete();
        build_frame(MAC_BOARD, 8'd23);
        push_end(16'd0, 1'b1);
        send_frame(-1, 1'b0, 1'b0);

        repeat (10) @(posedge eth_tx_clk);
        chk("words_left", exp_words.size(), 32'd0);
        chk("ends_left", exp_ends.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
